// File: rtl/fp8_unpack_seq.sv
// Serializes the enabled FP8 lanes of a packed input word, one lane per cycle,
// lowest lane first, with lane index and last-lane flag on a registered output.
module fp8_unpack_seq #(
  parameter int LANES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [8*LANES-1:0]       i_data,
  input  logic [LANES-1:0]         i_mask,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [7:0]               o_fp8,
  output logic [$clog2(LANES)-1:0] o_lane,
  output logic                     o_last
);

  localparam int LW = $clog2(LANES);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [8*LANES-1:0]   data_q;
  logic [8*LANES-1:0]   data_nx;
  logic [LANES-1:0]     mask_q;
  logic [LANES-1:0]     mask_nx;
  logic [7:0]           fp8_nx;
  logic [LW-1:0]        lane_nx;
  logic                 last_nx;
  logic [LW-1:0]        sel_lane;
  logic                 in_fire;
  logic                 out_fire;

  // Priority search from the top down so the lowest set bit wins.
  function automatic logic [LW-1:0] lowest_lane(input logic [LANES-1:0] m);
    lowest_lane = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (m[k]) lowest_lane = LW'(k);
    end
  endfunction

  assign o_valid  = (state == SEND);
  assign i_ready  = !rst && ((state == IDLE) || ((state == SEND) && o_ready && o_last));
  assign in_fire  = i_valid && i_ready;
  assign out_fire = o_valid && o_ready;

  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    mask_nx  = mask_q;
    fp8_nx   = o_fp8;
    lane_nx  = o_lane;
    last_nx  = o_last;
    sel_lane = '0;

    if (out_fire && !o_last) begin
      sel_lane = lowest_lane(mask_q);
      mask_nx  = mask_q & ~(LANES'(1) << sel_lane);
      fp8_nx   = data_q[8*sel_lane +: 8];
      lane_nx  = sel_lane;
      last_nx  = (mask_nx == '0);
    end else if (in_fire) begin
      // An empty mask is swallowed; if it arrives on the last lane we still retire.
      if (i_mask != '0) begin
        sel_lane = lowest_lane(i_mask);
        data_nx  = i_data;
        mask_nx  = i_mask & ~(LANES'(1) << sel_lane);
        fp8_nx   = i_data[8*sel_lane +: 8];
        lane_nx  = sel_lane;
        last_nx  = (mask_nx == '0);
        state_nx = SEND;
      end else begin
        state_nx = IDLE;
      end
    end else if (out_fire) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      mask_q <= '0;
      o_fp8  <= 8'h00;
      o_lane <= '0;
      o_last <= 1'b0;
    end else begin
      state  <= state_nx;
      data_q <= data_nx;
      mask_q <= mask_nx;
      o_fp8  <= fp8_nx;
      o_lane <= lane_nx;
      o_last <= last_nx;
    end
  end

endmodule

// File: tb/tb_fp8_unpack_seq.sv
// Self-checking bench for fp8_unpack_seq: a queue of expected beats built from
// each accepted word is compared against the DUT every cycle.
module tb_fp8_unpack_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [63:0] i_data;
  logic [7:0]  i_mask;
  logic        o_valid;
  logic        o_ready;
  logic [7:0]  o_fp8;
  logic [2:0]  o_lane;
  logic        o_last;

  always #5 clk = ~clk;

  fp8_unpack_seq #(.LANES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_mask  (i_mask),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_fp8   (o_fp8),
    .o_lane  (o_lane),
    .o_last  (o_last)
  );

  typedef struct packed {
    logic [7:0] fp8;
    logic [2:0] lane;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    checks = 0;
  int    passed = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual === required) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
  endtask

  // Every enabled lane becomes one beat, ascending; last marks the highest enabled lane.
  task automatic push_word(input logic [63:0] d, input logic [7:0] m);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        b.fp8  = d[8*k +: 8];
        b.lane = 3'(k);
        b.last = ((m >> (k + 1)) == 8'h00);
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic logic model_i_ready();
    if (rst) return 1'b0;
    if (exp_q.size() == 0) return 1'b1;
    return o_ready && exp_q[0].last;
  endfunction

  task automatic compare_outputs();
    check_output("o_valid", o_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_output("o_fp8", o_fp8, exp_q[0].fp8);
      check_output("o_lane", o_lane, exp_q[0].lane);
      check_output("o_last", o_last, exp_q[0].last);
    end
  endtask

  // Called at a negedge: drive inputs, check i_ready, advance one clock and compare.
  task automatic apply_stimulus(input logic v, input logic [63:0] d, input logic [7:0] m,
                                input logic r, output logic accepted);
    logic exp_ir;
    logic out_fire;
    beat_t b;
    i_valid = v;
    i_data  = d;
    i_mask  = m;
    o_ready = r;
    #1;
    exp_ir = model_i_ready();
    check_output("i_ready", i_ready, exp_ir);
    if (o_valid && o_ready) begin
      b.fp8  = o_fp8;
      b.lane = o_lane;
      b.last = o_last;
      got_q.push_back(b);
    end
    out_fire = !rst && (exp_q.size() != 0) && r;
    accepted = v && exp_ir;
    @(posedge clk);
    if (out_fire) void'(exp_q.pop_front());
    if (accepted) push_word(d, m);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] m, input logic r);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) apply_stimulus(1'b1, d, m, r, acc);
    if (!acc) check_output("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) apply_stimulus(1'b0, 64'h0, 8'h00, 1'b1, acc);
    if (exp_q.size() != 0) check_output("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_beat(input string name, input int idx, input logic [7:0] f,
                             input logic [2:0] l, input logic last);
    if (idx >= got_q.size()) check_output(name, 64'hDEAD, {f, l, last});
    else check_output(name, {got_q[idx].fp8, got_q[idx].lane, got_q[idx].last}, {f, l, last});
  endtask

  initial begin
    logic acc;
    logic [7:0] m;
    logic [63:0] d;
    int sel;

    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_mask  = '0;
    o_ready = 1'b0;
    #12;
    check_output("reset_o_valid", o_valid, 1'b0);
    check_output("reset_o_fp8", o_fp8, 8'h00);
    check_output("reset_o_lane", o_lane, 3'd0);
    check_output("reset_o_last", o_last, 1'b0);
    check_output("reset_i_ready", i_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Full mask, continuous ready.
    got_q.delete();
    send_word(64'h8877665544332211, 8'hFF, 1'b1);
    drain();
    check_output("full_count", got_q.size(), 8);
    for (int k = 0; k < 8; k++) expect_beat("full_beat", k, 8'((k + 1) * 17), 3'(k), k == 7);

    // Sparse word then back-to-back single-lane word.
    got_q.delete();
    send_word(64'hA7A6A5A4A3A2A1A0, 8'b1010_0100, 1'b1);
    send_word(64'hB7B6B5B4B3B2B1B0, 8'h01, 1'b1);
    drain();
    check_output("sparse_count", got_q.size(), 4);
    expect_beat("sparse_beat0", 0, 8'hA2, 3'd2, 1'b0);
    expect_beat("sparse_beat1", 1, 8'hA5, 3'd5, 1'b0);
    expect_beat("sparse_beat2", 2, 8'hA7, 3'd7, 1'b1);
    expect_beat("sparse_beat3", 3, 8'hB0, 3'd0, 1'b1);

    // Zero mask word is swallowed.
    got_q.delete();
    send_word(64'h1111111111111111, 8'h00, 1'b1);
    send_word(64'h9A00000000000000, 8'h80, 1'b1);
    drain();
    check_output("zero_count", got_q.size(), 1);
    expect_beat("zero_beat0", 0, 8'h9A, 3'd7, 1'b1);

    // Backpressure at lane 3.
    got_q.delete();
    send_word(64'hC7C6C5C4C3C2C1C0, 8'hFF, 1'b1);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 64'h0, 8'h00, 1'b1, acc);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 64'h5, 8'h01, 1'b0, acc);
    drain();
    check_output("bp_count", got_q.size(), 8);
    for (int k = 0; k < 8; k++) expect_beat("bp_beat", k, 8'hC0 + 8'(k), 3'(k), k == 7);

    // Reset mid-word.
    got_q.delete();
    send_word(64'hD7D6D5D4D3D2D1D0, 8'hFF, 1'b1);
    for (int k = 0; k < 2; k++) apply_stimulus(1'b0, 64'h0, 8'h00, 1'b1, acc);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_output("midrst_o_valid", o_valid, 1'b0);
    check_output("midrst_o_fp8", o_fp8, 8'h00);
    check_output("midrst_o_lane", o_lane, 3'd0);
    check_output("midrst_o_last", o_last, 1'b0);
    apply_stimulus(1'b1, 64'hEEEE, 8'hFF, 1'b1, acc);
    rst = 1'b0;
    got_q.delete();
    send_word(64'h000000E400000000, 8'h10, 1'b1);
    drain();
    check_output("rst_count", got_q.size(), 1);
    expect_beat("rst_beat0", 0, 8'hE4, 3'd4, 1'b1);

    // Special FP8 patterns pass through bit-exact.
    got_q.delete();
    send_word(64'h0000_0100_8055_7F7C, 8'b0010_1011, 1'b1);
    drain();
    check_output("special_count", got_q.size(), 4);
    expect_beat("special_inf", 0, 8'h7C, 3'd0, 1'b0);
    expect_beat("special_nan", 1, 8'h7F, 3'd1, 1'b0);
    expect_beat("special_negzero", 2, 8'h80, 3'd3, 1'b0);
    expect_beat("special_sub", 3, 8'h01, 3'd5, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0) m = 8'h00;
      else if (sel == 1) m = 8'hFF;
      else m = 8'($urandom);
      d = {$urandom, $urandom};
      apply_stimulus($urandom_range(0, 2) != 0, d, m, $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fp8_unpack_seq.md
# fp8_unpack_seq

Serializer that sits directly upstream of the FP8→FP64 converter. It accepts a 64-bit word holding eight packed FP8 values plus a per-lane enable mask, and emits the enabled lanes one per cycle as FP8 values with lane index and last flag. Both sides use a valid/ready handshake. It feeds the converter's FP8 input; the converter's FP64 result is tagged downstream with `o_lane`.

## Interface
- `LANES`, default 8: number of FP8 lanes per input word; fixed at 8 for this release, width of `i_data` = 8*LANES.
- `rst`  input  1  asynchronous, active-high reset
- `clk`  input  1  clock; all state updates on rising edge
- `i_valid`  input  1  input word valid
- `i_ready`  output  1  block can accept a word this cycle
- `i_data`  input  64  packed FP8; lane k = bits [8k+7:8k]; FP8 layout {sign, exp[4:0], sig[1:0]}
- `i_mask`  input  8  lane enable; bit k enables lane k
- `o_valid`  output  1  `o_fp8` / `o_lane` / `o_last` valid
- `o_ready`  input  1  downstream accepts this cycle
- `o_fp8`  output  8  FP8 value of current lane, bit-exact copy of input bits
- `o_lane`  output  3  lane index of `o_fp8`
- `o_last`  output  1  current lane is the highest enabled lane of its word

## Operation
- Holding register: `data_q[63:0]` and `mask_q[7:0]` (remaining lanes, cleared as sent).
- State machine:
  - IDLE (holding register empty): `o_valid`=0.
  - SEND (lanes pending): `o_valid`=1.
- Input transfer when `i_valid & i_ready`.
- `i_ready` = !rst & (state==IDLE | (state==SEND & o_ready & o_last)).
- Accept with `i_mask` != 0:
  - load `data_q`, `mask_q`;
  - select lowest set lane L;
  - drive `o_fp8`=lane L, `o_lane`=L, `o_last`=1 if no higher mask bit is set;
  - clear bit L in `mask_q`;
  - go to SEND.
- Accept with `i_mask` == 0: word consumed and discarded. No output, state unchanged (IDLE remains IDLE). If it arrives while the last lane of the previous word transfers, go to IDLE.
- Output transfer (`o_valid & o_ready`):
  - If `o_last`=0: present next lowest remaining lane of `mask_q` the next cycle, clear its bit, recompute `o_last`.
  - If `o_last`=1: take a new word if one is accepted in the same cycle (rules above); else go to IDLE.
- Stall (`o_valid & !o_ready`): `o_fp8`, `o_lane`, `o_last`, `data_q`, `mask_q` all hold; `i_ready`=0.
- Lanes are emitted in strictly ascending index order; disabled lanes are never emitted.
- No value interpretation: NaN, Inf, zero and subnormal patterns pass through unchanged.

## Timing
- Latency: word accepted at edge N → first lane valid after edge N (registered output, 1 cycle).
- Throughput: popcount(`i_mask`) cycles per word with `o_ready` held high; no bubble between words when the next word is offered during the last lane.
- An all-zero-mask word costs 1 input cycle and produces 0 output cycles.
- `i_ready` is combinational from state, `o_ready` and `o_last`. `o_*` are registered.
- Reset (async assert, any time including mid-word): state=IDLE, `o_valid`=0, `o_fp8`=8'h00, `o_lane`=0, `o_last`=0, `mask_q`=0, `data_q`=0, `i_ready`=0 while `rst`=1.
  - A word in progress is lost.
  - First acceptance is possible on the first rising edge after `rst` deasserts.
- `o_valid` never drops while `o_ready`=0 (AXI-style stability rule).

## Test plan
- Full mask: `i_data`=64'h8877665544332211, `i_mask`=8'hFF, `o_ready`=1 → 8 consecutive outputs: 11/0 … 88/7, `o_last` only on lane 7; `i_ready` high in the lane-7 cycle.
- Sparse mask and back-to-back: word A mask 8'b1010_0100, then word B mask 8'h01 offered continuously → lanes 2, 5, 7 of A (`o_last` on 7), then B lane 0 on the next cycle with no bubble.
- Zero mask: word mask 8'h00 followed by word mask 8'h80 → first accepted with no output; second yields one output lane 7, `o_last`=1.
- Backpressure: `o_ready` low for 3 cycles at lane 3 of an FP mask → `o_fp8`/`o_lane` stable and `i_ready`=0 throughout; resumes at lane 4 with no lane lost or duplicated.
- Reset mid-word: assert `rst` after lane 2 of an FP word → `o_valid`=0 immediately and all outputs zero; after release, new word mask 8'h10 yields only lane 4.
- Special patterns: lanes holding 8'h7C (Inf), 8'h7F (NaN), 8'h80 (−0), 8'h01 (subnormal) → emitted bit-exact, in order.
